mpx_hilo_unit: RTL and testbench

- Owns the architectural HI/LO registers for the MPX core.
- Sits downstream of mpx_divider and the multiplier, and consumes their writeback_valid/hi/lo results.
- Serves MFHI/MFLO/MTHI/MTLO and interlocks the issue stage while a MULT/MULTU/DIV/DIVU result is outstanding.
- Produces a GPR writeback for MFHI/MFLO and a sticky error flag if a result never arrives.

---
 rtl/mpx_hilo_unit_pkg.sv | 51 +++++
 rtl/mpx_hilo_unit_timeout.sv | 44 ++++
 rtl/mpx_hilo_unit.sv | 178 +++++++++++++++++
 tb/tb_mpx_hilo_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpx_hilo_unit_pkg.sv
// Shared definitions for the HI/LO unit.
// Holds the MIPS opcode/function constants, the instruction field ranges,
// the HI/LO FSM state encoding, and the decode helper that sorts an
// instruction into the classes the unit cares about.
package mpx_hilo_unit_pkg;

  // Primary opcode and SPECIAL function codes
  localparam logic [5:0] INSTR_R_SPECIAL = 6'h00;
  localparam logic [5:0] INSTR_R_MFHI    = 6'h10;
  localparam logic [5:0] INSTR_R_MTHI    = 6'h11;
  localparam logic [5:0] INSTR_R_MFLO    = 6'h12;
  localparam logic [5:0] INSTR_R_MTLO    = 6'h13;
  localparam logic [5:0] INSTR_R_MULT    = 6'h18;
  localparam logic [5:0] INSTR_R_MULTU   = 6'h19;
  localparam logic [5:0] INSTR_R_DIV     = 6'h1a;
  localparam logic [5:0] INSTR_R_DIVU    = 6'h1b;

  // Instruction field ranges
  localparam int OPCODE_INST_R_MSB = 31;
  localparam int OPCODE_INST_R_LSB = 26;
  localparam int OPCODE_FUNC_R_MSB = 5;
  localparam int OPCODE_FUNC_R_LSB = 0;

  typedef enum logic [1:0] {
    HILO_STATE_IDLE     = 2'd0,
    HILO_STATE_MUL_PEND = 2'd1,
    HILO_STATE_DIV_PEND = 2'd2
  } hilo_state_e;

  typedef enum logic [1:0] {
    HILO_CLASS_OTHER = 2'd0,
    HILO_CLASS_START = 2'd1,
    HILO_CLASS_MF    = 2'd2,
    HILO_CLASS_MT    = 2'd3
  } hilo_class_e;

  function automatic hilo_class_e hilo_decode(input logic [5:0] inst_r,
                                              input logic [5:0] func_r);
    hilo_decode = HILO_CLASS_OTHER;
    if (inst_r == INSTR_R_SPECIAL) begin
      case (func_r)
        INSTR_R_MULT, INSTR_R_MULTU,
        INSTR_R_DIV,  INSTR_R_DIVU:  hilo_decode = HILO_CLASS_START;
        INSTR_R_MFHI, INSTR_R_MFLO:  hilo_decode = HILO_CLASS_MF;
        INSTR_R_MTHI, INSTR_R_MTLO:  hilo_decode = HILO_CLASS_MT;
        default:                     hilo_decode = HILO_CLASS_OTHER;
      endcase
    end
  endfunction

endpackage

// File: rtl/mpx_hilo_unit_timeout.sv
// Pending-cycle watchdog for the HI/LO unit.
// Counts cycles while enabled; clear forces the count to zero.
// expire_o is high during the cycle in which the count has reached
// TIMEOUT_CYCLES-1, so the owner can abort on that edge.
//   clk_i, rst_i : clock, async active-high reset
//   clear_i      : hold count at zero (has priority over enable_i)
//   enable_i     : advance count by one per cycle
//   expire_o     : terminal count reached while enabled
module mpx_hilo_unit_timeout #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMER_W        = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = enable_i && !clear_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/mpx_hilo_unit.sv
// Architectural HI/LO register owner for the MPX core.
// Serves MFHI/MFLO/MTHI/MTLO, absorbs multiplier/divider writebacks, and
// stalls issue of HI/LO-touching instructions while a MULT/MULTU/DIV/DIVU
// result is outstanding. A result that never arrives is aborted after
// TIMEOUT_CYCLES and latched in the sticky error_o flag.
//   opcode_*       : issue-stage instruction, accept_o=0 stalls it
//   mul_/div_*     : result strobes with HI/LO payloads
//   writeback_*    : GPR write for MFHI/MFLO (1-cycle valid pulse)
//   hi_o, lo_o     : current HI/LO
//   busy_o         : mul/div result pending
//   error_o        : sticky timeout flag
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | nothing outstanding, all HI/LO instructions accepted
// MUL_PEND | MULT/MULTU issued, waiting for a result strobe
// DIV_PEND | DIV/DIVU issued, waiting for a result strobe
module mpx_hilo_unit
  import mpx_hilo_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMER_W        = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        opcode_valid_i,
  input  logic [31:0] opcode_opcode_i,
  input  logic [4:0]  opcode_rd_idx_i,
  input  logic [31:0] opcode_rs_operand_i,
  output logic        opcode_accept_o,
  input  logic        mul_writeback_valid_i,
  input  logic [31:0] mul_writeback_hi_i,
  input  logic [31:0] mul_writeback_lo_i,
  input  logic        div_writeback_valid_i,
  input  logic [31:0] div_writeback_hi_i,
  input  logic [31:0] div_writeback_lo_i,
  output logic        writeback_valid_o,
  output logic [4:0]  writeback_idx_o,
  output logic [31:0] writeback_value_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        error_o
);

  hilo_state_e state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        error_q, error_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_idx_q, wb_idx_d;
  logic [31:0] wb_value_q, wb_value_d;

  logic [5:0]  inst_r;
  logic [5:0]  func_r;
  hilo_class_e op_class;
  logic        pending;
  logic        fire;
  logic        any_strobe;
  logic        timer_clear;
  logic        timer_enable;
  logic        timer_expire;

  // rs/rt/rd/shamt are not needed to classify HI/LO instructions
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^opcode_opcode_i[OPCODE_INST_R_LSB-1:OPCODE_FUNC_R_MSB+1];

  assign inst_r     = opcode_opcode_i[OPCODE_INST_R_MSB:OPCODE_INST_R_LSB];
  assign func_r     = opcode_opcode_i[OPCODE_FUNC_R_MSB:OPCODE_FUNC_R_LSB];
  assign op_class   = hilo_decode(inst_r, func_r);
  assign pending    = (state_q != HILO_STATE_IDLE);
  assign any_strobe = mul_writeback_valid_i || div_writeback_valid_i;

  // Unrelated instructions keep flowing while a result is outstanding
  assign opcode_accept_o = !(pending && opcode_valid_i && (op_class != HILO_CLASS_OTHER));
  assign fire            = opcode_valid_i && opcode_accept_o;

  // Counter sits at zero throughout IDLE, so it starts from zero on entry
  assign timer_clear  = !pending;
  assign timer_enable = pending;

  mpx_hilo_unit_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMER_W       (TIMER_W)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (timer_clear),
    .enable_i(timer_enable),
    .expire_o(timer_expire)
  );

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    error_d    = error_q;
    wb_valid_d = 1'b0;
    wb_idx_d   = wb_idx_q;
    wb_value_d = wb_value_q;

    // A result always lands, even with nothing pending (e.g. after a
    // flush); the divider wins if both units strobe together.
    if (div_writeback_valid_i) begin
      hi_d = div_writeback_hi_i;
      lo_d = div_writeback_lo_i;
    end else if (mul_writeback_valid_i) begin
      hi_d = mul_writeback_hi_i;
      lo_d = mul_writeback_lo_i;
    end

    case (state_q)
      HILO_STATE_IDLE: begin
        if (fire && (op_class == HILO_CLASS_START)) begin
          state_d = (func_r == INSTR_R_DIV || func_r == INSTR_R_DIVU) ?
                    HILO_STATE_DIV_PEND : HILO_STATE_MUL_PEND;
        end
      end
      HILO_STATE_MUL_PEND,
      HILO_STATE_DIV_PEND: begin
        // Either unit's strobe retires the pending op
        if (any_strobe) begin
          state_d = HILO_STATE_IDLE;
        end else if (timer_expire) begin
          state_d = HILO_STATE_IDLE;
          error_d = 1'b1;
        end
      end
      default: state_d = HILO_STATE_IDLE;
    endcase

    // MT can only fire in IDLE; being younger than any stray result
    // arriving in the same cycle, it overrides that half.
    if (fire && (op_class == HILO_CLASS_MT)) begin
      if (func_r == INSTR_R_MTHI) begin
        hi_d = opcode_rs_operand_i;
      end else begin
        lo_d = opcode_rs_operand_i;
      end
    end

    // MF reads the registered value: no bypass from the strobe inputs
    if (fire && (op_class == HILO_CLASS_MF)) begin
      wb_valid_d = 1'b1;
      wb_idx_d   = opcode_rd_idx_i;
      wb_value_d = (func_r == INSTR_R_MFHI) ? hi_q : lo_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= HILO_STATE_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      error_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
      wb_value_q <= '0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      error_q    <= error_d;
      wb_valid_q <= wb_valid_d;
      wb_idx_q   <= wb_idx_d;
      wb_value_q <= wb_value_d;
    end
  end

  assign hi_o              = hi_q;
  assign lo_o              = lo_q;
  assign busy_o            = pending;
  assign error_o           = error_q;
  assign writeback_valid_o = wb_valid_q;
  assign writeback_idx_o   = wb_idx_q;
  assign writeback_value_o = wb_value_q;

endmodule

// File: tb/tb_mpx_hilo_unit.sv
// Bench for mpx_hilo_unit: a vector table from reset, directed multi-cycle
// scenarios, and randomized traffic, all compared against a small
// behavioural model of the HI/LO architectural state.
module tb_mpx_hilo_unit;

  localparam int TIMEOUT = 64;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADDU  = 6'h21;

  localparam int C_OTHER = 0;
  localparam int C_START = 1;
  localparam int C_MF    = 2;
  localparam int C_MT    = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        opcode_valid_i;
  logic [31:0] opcode_opcode_i;
  logic [4:0]  opcode_rd_idx_i;
  logic [31:0] opcode_rs_operand_i;
  logic        opcode_accept_o;
  logic        mul_writeback_valid_i;
  logic [31:0] mul_writeback_hi_i;
  logic [31:0] mul_writeback_lo_i;
  logic        div_writeback_valid_i;
  logic [31:0] div_writeback_hi_i;
  logic [31:0] div_writeback_lo_i;
  logic        writeback_valid_o;
  logic [4:0]  writeback_idx_o;
  logic [31:0] writeback_value_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;
  logic        error_o;

  mpx_hilo_unit #(.TIMEOUT_CYCLES(TIMEOUT), .TIMER_W(7)) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .opcode_valid_i       (opcode_valid_i),
    .opcode_opcode_i      (opcode_opcode_i),
    .opcode_rd_idx_i      (opcode_rd_idx_i),
    .opcode_rs_operand_i  (opcode_rs_operand_i),
    .opcode_accept_o      (opcode_accept_o),
    .mul_writeback_valid_i(mul_writeback_valid_i),
    .mul_writeback_hi_i   (mul_writeback_hi_i),
    .mul_writeback_lo_i   (mul_writeback_lo_i),
    .div_writeback_valid_i(div_writeback_valid_i),
    .div_writeback_hi_i   (div_writeback_hi_i),
    .div_writeback_lo_i   (div_writeback_lo_i),
    .writeback_valid_o    (writeback_valid_o),
    .writeback_idx_o      (writeback_idx_o),
    .writeback_value_o    (writeback_value_o),
    .hi_o                 (hi_o),
    .lo_o                 (lo_o),
    .busy_o               (busy_o),
    .error_o              (error_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the architectural state
  logic [31:0] m_hi, m_lo, m_wb_val;
  logic [4:0]  m_wb_idx;
  logic        m_wb_v, m_err, m_pend;
  int          m_age;
  logic        last_acc;

  function automatic logic [31:0] rtype(input logic [5:0] f);
    rtype = {26'd0, f};
  endfunction

  function automatic int cls_of(input logic [31:0] instr);
    logic [5:0] f;
    f = instr[5:0];
    if (instr[31:26] != 6'd0) return C_OTHER;
    if (f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU) return C_START;
    if (f == F_MFHI || f == F_MFLO) return C_MF;
    if (f == F_MTHI || f == F_MTLO) return C_MT;
    return C_OTHER;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_wb_val = '0; m_wb_idx = '0;
    m_wb_v = 1'b0; m_err = 1'b0; m_pend = 1'b0; m_age = 0;
  endtask

  task automatic check_state();
    chk("hi", hi_o, m_hi);
    chk("lo", lo_o, m_lo);
    chk("busy", {31'd0, busy_o}, {31'd0, m_pend});
    chk("error", {31'd0, error_o}, {31'd0, m_err});
    chk("wb_valid", {31'd0, writeback_valid_o}, {31'd0, m_wb_v});
    chk("wb_idx", {27'd0, writeback_idx_o}, {27'd0, m_wb_idx});
    chk("wb_value", writeback_value_o, m_wb_val);
  endtask

  // One clock: drive at negedge, check accept, clock, update model, check
  task automatic step(input logic v, input logic [31:0] instr, input logic [4:0] rd,
                      input logic [31:0] rs, input logic mv, input logic [31:0] mh,
                      input logic [31:0] ml, input logic dv, input logic [31:0] dh,
                      input logic [31:0] dl);
    int c;
    logic exp_acc, fire;
    logic [31:0] old_hi, old_lo;
    opcode_valid_i = v; opcode_opcode_i = instr; opcode_rd_idx_i = rd;
    opcode_rs_operand_i = rs;
    mul_writeback_valid_i = mv; mul_writeback_hi_i = mh; mul_writeback_lo_i = ml;
    div_writeback_valid_i = dv; div_writeback_hi_i = dh; div_writeback_lo_i = dl;
    #1;
    c = cls_of(instr);
    exp_acc = !(m_pend && v && c != C_OTHER);
    last_acc = opcode_accept_o;
    chk("accept", {31'd0, opcode_accept_o}, {31'd0, exp_acc});
    @(posedge clk_i);
    fire = v && exp_acc;
    old_hi = m_hi; old_lo = m_lo;
    m_wb_v = 1'b0;
    if (fire && c == C_MF) begin
      m_wb_v = 1'b1;
      m_wb_idx = rd;
      m_wb_val = (instr[5:0] == F_MFHI) ? old_hi : old_lo;
    end
    if (dv) begin m_hi = dh; m_lo = dl; end
    else if (mv) begin m_hi = mh; m_lo = ml; end
    if (m_pend) begin
      if (mv || dv) m_pend = 1'b0;
      else if (m_age == TIMEOUT - 1) begin m_pend = 1'b0; m_err = 1'b1; end
      else m_age++;
    end else begin
      if (fire && c == C_START) begin m_pend = 1'b1; m_age = 0; end
      if (fire && c == C_MT) begin
        if (instr[5:0] == F_MTHI) m_hi = rs; else m_lo = rs;
      end
    end
    @(negedge clk_i);
    check_state();
  endtask

  task automatic op(input logic [5:0] f, input logic [4:0] rd, input logic [31:0] rs);
    step(1'b1, rtype(f), rd, rs, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    opcode_valid_i = 1'b0; opcode_opcode_i = '0; opcode_rd_idx_i = '0;
    opcode_rs_operand_i = '0;
    mul_writeback_valid_i = 1'b0; mul_writeback_hi_i = '0; mul_writeback_lo_i = '0;
    div_writeback_valid_i = 1'b0; div_writeback_hi_i = '0; div_writeback_lo_i = '0;
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] rs;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        e_wbv;
    logic [4:0]  e_idx;
    logic [31:0] e_val;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, rtype(F_MTHI), 5'd0,  32'hA5A5_0001, 32'hA5A5_0001, 32'h0,      1'b0, 5'd0,  32'h0};
    tbl[1] = '{1'b1, rtype(F_MTLO), 5'd0,  32'h0000_BEEF, 32'hA5A5_0001, 32'hBEEF,   1'b0, 5'd0,  32'h0};
    tbl[2] = '{1'b1, rtype(F_MFHI), 5'd5,  32'h0,         32'hA5A5_0001, 32'hBEEF,   1'b1, 5'd5,  32'hA5A5_0001};
    tbl[3] = '{1'b1, rtype(F_MFLO), 5'd31, 32'h0,         32'hA5A5_0001, 32'hBEEF,   1'b1, 5'd31, 32'hBEEF};
    tbl[4] = '{1'b1, rtype(F_ADDU), 5'd7,  32'h1,         32'hA5A5_0001, 32'hBEEF,   1'b0, 5'd31, 32'hBEEF};
    tbl[5] = '{1'b0, rtype(F_MFHI), 5'd2,  32'h0,         32'hA5A5_0001, 32'hBEEF,   1'b0, 5'd31, 32'hBEEF};
    tbl[6] = '{1'b1, rtype(F_MFHI), 5'd0,  32'h0,         32'hA5A5_0001, 32'hBEEF,   1'b1, 5'd0,  32'hA5A5_0001};
    tbl[7] = '{1'b1, rtype(F_MTHI), 5'd0,  32'h0,         32'h0,         32'hBEEF,   1'b0, 5'd0,  32'hA5A5_0001};
    tbl[8] = '{1'b1, rtype(F_MFHI), 5'd9,  32'h0,         32'h0,         32'hBEEF,   1'b1, 5'd9,  32'h0};

    do_reset();
    #1;
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_lo", lo_o, 32'h0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_accept", {31'd0, opcode_accept_o}, 32'd1);
    chk("rst_error", {31'd0, error_o}, 32'd0);
    chk("rst_wb", {26'd0, writeback_valid_o, writeback_idx_o}, 32'd0);
    chk("rst_wbval", writeback_value_o, 32'h0);
    @(negedge clk_i);

    // Table vectors from reset
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].instr, tbl[i].rd, tbl[i].rs,
           1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
      chk("tbl_hi", hi_o, tbl[i].e_hi);
      chk("tbl_lo", lo_o, tbl[i].e_lo);
      chk("tbl_wbv", {31'd0, writeback_valid_o}, {31'd0, tbl[i].e_wbv});
      chk("tbl_idx", {27'd0, writeback_idx_o}, {27'd0, tbl[i].e_idx});
      chk("tbl_val", writeback_value_o, tbl[i].e_val);
    end

    // Async reset mid DIV_PEND at timer=10
    op(F_MTHI, 5'd0, 32'h7777_0000);
    op(F_DIV, 5'd0, 32'd0);
    repeat (10) idle();
    chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_hi", hi_o, 32'h0);
    chk("midrst_lo", lo_o, 32'h0);
    chk("midrst_accept", {31'd0, opcode_accept_o}, 32'd1);
    chk("midrst_error", {31'd0, error_o}, 32'd0);
    do_reset();

    // MTHI then MFHI rd=8
    op(F_MTHI, 5'd0, 32'h1234_5678);
    chk("mthi_hi", hi_o, 32'h1234_5678);
    op(F_MFHI, 5'd8, 32'd0);
    chk("mfhi_wbv", {31'd0, writeback_valid_o}, 32'd1);
    chk("mfhi_idx", {27'd0, writeback_idx_o}, 32'd8);
    chk("mfhi_val", writeback_value_o, 32'h1234_5678);
    idle();
    chk("mfhi_pulse", {31'd0, writeback_valid_o}, 32'd0);
    chk("mfhi_hold", writeback_value_o, 32'h1234_5678);

    // DIV then MFLO stalled until the divider strobe
    op(F_DIV, 5'd0, 32'd0);
    for (int i = 0; i < 33; i++) begin
      op(F_MFLO, 5'd3, 32'd0);
      chk("mflo_stall", {31'd0, last_acc}, 32'd0);
    end
    step(1'b1, rtype(F_MFLO), 5'd3, 32'd0, 1'b0, 32'd0, 32'd0,
         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    chk("div_strobe_acc", {31'd0, last_acc}, 32'd0);
    chk("div_lo", lo_o, 32'hFFFF_FFFD);
    chk("div_hi", hi_o, 32'hFFFF_FFFF);
    op(F_MFLO, 5'd3, 32'd0);
    chk("mflo_acc", {31'd0, last_acc}, 32'd1);
    chk("mflo_val", writeback_value_o, 32'hFFFF_FFFD);
    chk("mflo_idx", {27'd0, writeback_idx_o}, 32'd3);

    // DIVU blocked during DIV_PEND, ADDU and an I-type lookalike pass
    op(F_DIV, 5'd0, 32'd0);
    for (int i = 0; i < 6; i++) begin
      op(F_DIVU, 5'd0, 32'd0);
      chk("divu_stall", {31'd0, last_acc}, 32'd0);
      if (i == 2) begin
        op(F_ADDU, 5'd4, 32'd0);
        chk("addu_pass", {31'd0, last_acc}, 32'd1);
        step(1'b1, {6'h09, 20'd0, F_MULT}, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0,
             1'b0, 32'd0, 32'd0);
        chk("itype_pass", {31'd0, last_acc}, 32'd1);
      end
    end
    step(1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h11, 32'h22);
    chk("divu_done_busy", {31'd0, busy_o}, 32'd0);

    // Simultaneous strobes in MUL_PEND: divider wins
    op(F_MULT, 5'd0, 32'd0);
    step(1'b0, 32'd0, 5'd0, 32'd0, 1'b1, 32'h1, 32'h2, 1'b1, 32'h3, 32'h4);
    chk("both_hi", hi_o, 32'h3);
    chk("both_lo", lo_o, 32'h4);
    chk("both_busy", {31'd0, busy_o}, 32'd0);

    // Wrong-unit strobe retires the pending op
    op(F_MULTU, 5'd0, 32'd0);
    idle();
    step(1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hAB, 32'hCD);
    chk("wrong_busy", {31'd0, busy_o}, 32'd0);
    chk("wrong_lo", lo_o, 32'hCD);

    // Strobe in IDLE still lands, no error
    step(1'b0, 32'd0, 5'd0, 32'd0, 1'b1, 32'h55, 32'h66, 1'b0, 32'd0, 32'd0);
    chk("idle_strobe_hi", hi_o, 32'h55);
    chk("idle_strobe_err", {31'd0, error_o}, 32'd0);

    // Timeout after 64 pending cycles, sticky error
    op(F_MTHI, 5'd0, 32'hCAFE_0001);
    op(F_MTLO, 5'd0, 32'h0BAD_0002);
    op(F_MULT, 5'd0, 32'd0);
    repeat (TIMEOUT - 1) idle();
    chk("to_busy_before", {31'd0, busy_o}, 32'd1);
    chk("to_err_before", {31'd0, error_o}, 32'd0);
    idle();
    chk("to_busy", {31'd0, busy_o}, 32'd0);
    chk("to_err", {31'd0, error_o}, 32'd1);
    chk("to_hi", hi_o, 32'hCAFE_0001);
    chk("to_lo", lo_o, 32'h0BAD_0002);
    op(F_MFHI, 5'd1, 32'd0);
    chk("to_accept", {31'd0, last_acc}, 32'd1);
    op(F_DIV, 5'd0, 32'd0);
    step(1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h9, 32'h8);
    chk("to_sticky", {31'd0, error_o}, 32'd1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        v, mv, dv;
      logic [31:0] instr;
      int          pick;
      pick = $urandom_range(0, 10);
      case (pick)
        0: instr = rtype(F_MULT);
        1: instr = rtype(F_MULTU);
        2: instr = rtype(F_DIV);
        3: instr = rtype(F_DIVU);
        4: instr = rtype(F_MFHI);
        5: instr = rtype(F_MFLO);
        6: instr = rtype(F_MTHI);
        7: instr = rtype(F_MTLO);
        8: instr = rtype(F_ADDU);
        default: instr = $urandom;
      endcase
      v = ($urandom_range(0, 3) != 0);
      mv = 1'b0; dv = 1'b0;
      if (m_pend) begin
        mv = ($urandom_range(0, 29) == 0);
        dv = ($urandom_range(0, 29) == 0);
      end else if (!v) begin
        mv = ($urandom_range(0, 19) == 0);
        dv = ($urandom_range(0, 19) == 0);
      end
      step(v, instr, 5'($urandom), $urandom, mv, $urandom, $urandom,
           dv, $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
